fxp_arith_unit: RTL and testbench

Parametrised, handshaked fixed-point arithmetic unit: signed Q(WIDTH-FBITS).FBITS add, subtract and multiply, plus unsigned square root, one operation in flight. It replaces the free-running, level-decoded fixed-point unit in the execute stage. Operations are accepted and returned with valid/ready handshakes, the multiplier is iterative at configurable chunk width, and overflow is reported explicitly.

---
 rtl/fxp_arith_unit_if.sv | 25 ++
 rtl/fxp_arith_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_fxp_arith_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fxp_arith_unit_if.sv
// Request/response handshake bundle for fxp_arith_unit: operation request in,
// result plus overflow flag out, each side with its own valid/ready pair.
interface fxp_arith_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       operation;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;

    modport master (
        output in_valid, operation, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, operation, operand_1, operand_2, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/fxp_arith_unit.sv
// Handshaked signed Q(WIDTH-FBITS).FBITS add/sub/mul and unsigned sqrt, one op in flight.
// Define FXU_SATURATE_EN to clamp ADD/SUB/MUL results on overflow instead of wrapping.
module fxp_arith_unit #(
    parameter int WIDTH     = 32,
    parameter int FBITS     = 10,
    parameter int MUL_CHUNK = 16
) (
    input  logic            clk,
    input  logic            reset,
    fxp_arith_unit_if.slave bus
);
    localparam int NCH   = WIDTH / MUL_CHUNK;
    localparam int P     = NCH * NCH;
    localparam int ITER  = (WIDTH + FBITS) / 2;
    localparam int XW    = WIDTH + FBITS;
    localparam int SW    = WIDTH + 2;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(((ITER > P) ? ITER : P) + 1);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef FXU_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_SQRT = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_SQRT,
        S_DONE
    } state_e;

    function automatic logic [WIDTH-1:0] clamp(input logic ovf, input logic neg,
                                               input logic [WIDTH-1:0] wrapped);
        logic [WIDTH-1:0] r;
        r = wrapped;
        if (SAT_EN && ovf)
            r = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return r;
    endfunction

    state_e                   r_state;
    state_e                   w_next;
    logic                     w_in_ready;
    logic                     w_out_valid;

    logic signed [WIDTH-1:0]  r_a;
    logic signed [WIDTH-1:0]  r_b;
    logic                     r_sub;
    logic                     r_neg;
    logic [PW-1:0]            r_acc;
    logic [CH_W-1:0]          r_ci;
    logic [CH_W-1:0]          r_cj;
    logic [CNT_W-1:0]         r_cnt;
    logic [XW-1:0]            r_x;
    logic [SW-1:0]            r_rem;
    logic [WIDTH-1:0]         r_root;
    logic [WIDTH-1:0]         r_result;
    logic                     r_overflow;

    logic signed [WIDTH:0]    w_sum;
    logic                     w_sum_ovf;
    logic [WIDTH-1:0]         w_ma;
    logic [WIDTH-1:0]         w_mb;
    int                       w_ia;
    int                       w_ib;
    int                       w_shamt;
    logic [MUL_CHUNK-1:0]     w_sa;
    logic [MUL_CHUNK-1:0]     w_sb;
    logic [2*MUL_CHUNK-1:0]   w_pp;
    logic [PW-1:0]            w_pp_sh;
    logic [PW-1:0]            w_prod_mag;
    logic [PW-1:0]            w_qmag;
    logic [PW-1:0]            w_q;
    logic                     w_mul_ovf;
    logic [SW-1:0]            w_rem_sh;
    logic [SW:0]              w_trial;
    logic                     w_fit;
    logic [WIDTH-1:0]         w_root_next;
    logic                     w_last_mul;
    logic                     w_last_sqrt;
    logic                     w_unused;

    always_comb begin
        // add/sub in WIDTH+1 bits so the carry-out sign survives for overflow detection
        if (r_sub)
            w_sum = $signed({r_a[WIDTH-1], r_a}) - $signed({r_b[WIDTH-1], r_b});
        else
            w_sum = $signed({r_a[WIDTH-1], r_a}) + $signed({r_b[WIDTH-1], r_b});
        w_sum_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

        // magnitude multiply, one chunk pair per cycle; sign applied after truncation
        w_ma       = r_a[WIDTH-1] ? WIDTH'(-r_a) : WIDTH'(r_a);
        w_mb       = r_b[WIDTH-1] ? WIDTH'(-r_b) : WIDTH'(r_b);
        w_ia       = int'(r_ci) * MUL_CHUNK;
        w_ib       = int'(r_cj) * MUL_CHUNK;
        w_shamt    = w_ia + w_ib;
        w_sa       = w_ma[w_ia +: MUL_CHUNK];
        w_sb       = w_mb[w_ib +: MUL_CHUNK];
        w_pp       = (2*MUL_CHUNK)'(w_sa) * (2*MUL_CHUNK)'(w_sb);
        w_pp_sh    = PW'(w_pp) << w_shamt;
        w_prod_mag = r_acc + w_pp_sh;
        w_qmag     = w_prod_mag >> FBITS;
        w_q        = r_neg ? -w_qmag : w_qmag;
        w_mul_ovf  = !((&w_q[PW-1:WIDTH-1]) || !(|w_q[PW-1:WIDTH-1]));

        // restoring square root: bring down two radicand bits, try (root<<2)|1
        w_rem_sh    = {r_rem[SW-3:0], r_x[XW-1 -: 2]};
        w_trial     = {1'b0, w_rem_sh} - {1'b0, r_root, 2'b01};
        w_fit       = ~w_trial[SW];
        w_root_next = {r_root[WIDTH-2:0], w_fit};

        w_last_mul  = (r_cnt == CNT_W'(P - 1));
        w_last_sqrt = (r_cnt == CNT_W'(ITER - 1));
        w_unused    = &{1'b0, r_rem[SW-1:SW-2]};
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    case (bus.operation)
                        OP_MUL:  w_next = S_MUL;
                        OP_SQRT: w_next = S_SQRT;
                        default: w_next = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB: w_next = S_DONE;
            S_MUL:    if (w_last_mul) w_next = S_DONE;
            S_SQRT:   if (w_last_sqrt) w_next = S_DONE;
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_neg      <= 1'b0;
            r_acc      <= '0;
            r_ci       <= '0;
            r_cj       <= '0;
            r_cnt      <= '0;
            r_x        <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a    <= bus.operand_1;
                        r_b    <= bus.operand_2;
                        r_sub  <= (bus.operation == OP_SUB);
                        r_neg  <= bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1];
                        r_acc  <= '0;
                        r_ci   <= '0;
                        r_cj   <= '0;
                        r_cnt  <= '0;
                        r_x    <= XW'(bus.operand_1) << FBITS;
                        r_rem  <= '0;
                        r_root <= '0;
                    end
                end
                S_ADDSUB: begin
                    r_result   <= clamp(w_sum_ovf, w_sum[WIDTH], w_sum[WIDTH-1:0]);
                    r_overflow <= w_sum_ovf;
                end
                S_MUL: begin
                    r_acc <= w_prod_mag;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cj == CH_W'(NCH - 1)) begin
                        r_cj <= '0;
                        r_ci <= r_ci + CH_W'(1);
                    end else begin
                        r_cj <= r_cj + CH_W'(1);
                    end
                    if (w_last_mul) begin
                        r_result   <= clamp(w_mul_ovf, r_neg, w_q[WIDTH-1:0]);
                        r_overflow <= w_mul_ovf;
                    end
                end
                S_SQRT: begin
                    r_rem  <= w_fit ? w_trial[SW-1:0] : w_rem_sh;
                    r_root <= w_root_next;
                    r_x    <= r_x << 2;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // a negative radicand still runs the full iteration count
                    if (w_last_sqrt) begin
                        r_result   <= r_a[WIDTH-1] ? '0 : w_root_next;
                        r_overflow <= r_a[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_fxp_arith_unit.sv
// Directed table-driven bench for fxp_arith_unit, plus backpressure and mid-op reset sequences.
module tb_fxp_arith_unit;
    localparam int W  = 32;
    localparam int NV = 17;

`ifdef FXU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fxp_arith_unit_if #(.WIDTH(W)) bus ();

    fxp_arith_unit #(.WIDTH(W), .FBITS(10), .MUL_CHUNK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one op, scramble the inputs afterwards, wait for out_valid, then take the result.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output logic ov, output int lat);
        int wait_n;
        wait_n = 0;
        while (bus.in_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1;
            wait_n++;
        end
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.operand_1 = a;
        bus.operand_2 = b;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.operation = ~op;
        bus.operand_1 = ~a;
        bus.operand_2 = ~b;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        ov  = bus.overflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic         o;
        int           l;
        int           n;
        logic         stable;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.operation = 2'b00;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{2'b00, 32'h00000C00, 32'h00000400, 32'h00001000, 1'b0, 2};
        vecs[1]  = '{2'b01, 32'h00000400, 32'h00000C00, 32'hFFFFF800, 1'b0, 2};
        vecs[2]  = '{2'b10, 32'h00000800, 32'h00000C00, 32'h00001800, 1'b0, 5};
        vecs[3]  = '{2'b10, 32'hFFFFF800, 32'h00000C00, 32'hFFFFE800, 1'b0, 5};
        vecs[4]  = '{2'b11, 32'h00001000, 32'h00000000, 32'h00000800, 1'b0, 22};
        vecs[5]  = '{2'b11, 32'h00000800, 32'h00000000, 32'h000005A8, 1'b0, 22};
        vecs[6]  = '{2'b11, 32'h80000000, 32'h12345678, 32'h00000000, 1'b1, 22};
        vecs[7]  = '{2'b00, 32'h7FFFFFFF, 32'h00000001, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b1, 2};
        vecs[8]  = '{2'b01, 32'h80000000, 32'h00000001, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 2};
        vecs[9]  = '{2'b10, 32'h00200000, 32'h00200000, SAT ? 32'h7FFFFFFF : 32'h00000000, 1'b1, 5};
        vecs[10] = '{2'b10, 32'hFFE00000, 32'h00200000, SAT ? 32'h80000000 : 32'h00000000, 1'b1, 5};
        vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000200, 32'h00000000, 1'b0, 5};
        vecs[12] = '{2'b10, 32'h00012345, 32'h00030000, 32'h00DA73C0, 1'b0, 5};
        vecs[13] = '{2'b10, 32'hFFFFFC00, 32'hFFFFFC00, 32'h00000400, 1'b0, 5};
        vecs[14] = '{2'b11, 32'h7FFFFFFF, 32'h00000000, 32'h0016A09E, 1'b0, 22};
        vecs[15] = '{2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 22};
        vecs[16] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 2};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset in_ready",  W'(bus.in_ready),  W'(1));
        chk("reset out_valid", W'(bus.out_valid), W'(0));
        chk("reset result",    bus.result,        32'h0);
        chk("reset overflow",  W'(bus.overflow),  W'(0));

        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, o, l);
            chk($sformatf("vec%0d result", i),   r,     vecs[i].res);
            chk($sformatf("vec%0d overflow", i), W'(o), W'(vecs[i].ovf));
            chk($sformatf("vec%0d latency", i),  W'(l), W'(vecs[i].lat));
        end
        chk("post-transfer in_ready",  W'(bus.in_ready),  W'(1));
        chk("post-transfer out_valid", W'(bus.out_valid), W'(0));

        // Backpressure: MUL result held for 10 cycles while an ADD request waits.
        bus.in_valid  = 1'b1;
        bus.operation = 2'b10;
        bus.operand_1 = 32'h00000800;
        bus.operand_2 = 32'h00000C00;
        @(posedge clk); #1;
        bus.operation = 2'b00;
        bus.operand_1 = 32'h00000001;
        bus.operand_2 = 32'h00000001;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp mul latency", W'(n + 1), W'(5));
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h00001800 || bus.in_ready !== 1'b0)
                stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp hold stable", W'(stable), W'(1));
        chk("bp hold result", bus.result, 32'h00001800);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp idle in_ready",  W'(bus.in_ready),  W'(1));
        chk("bp idle out_valid", W'(bus.out_valid), W'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp pending accepted", W'(bus.in_ready), W'(0));
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp add latency", W'(n + 1), W'(2));
        chk("bp add result",  bus.result, 32'h00000002);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset in SQRT iteration 7 aborts the op; a following ADD is unaffected.
        bus.in_valid  = 1'b1;
        bus.operation = 2'b11;
        bus.operand_1 = 32'h00001000;
        bus.operand_2 = 32'h0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("sqrt busy in_ready", W'(bus.in_ready), W'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort in_ready",  W'(bus.in_ready),  W'(1));
        chk("abort out_valid", W'(bus.out_valid), W'(0));
        chk("abort result",    bus.result,        32'h0);
        chk("abort overflow",  W'(bus.overflow),  W'(0));
        stable = 1'b1;
        for (int k = 0; k < 25; k++) begin
            if (bus.out_valid !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort no out_valid", W'(stable), W'(1));
        do_op(2'b00, 32'h00000001, 32'h00000001, r, o, l);
        chk("after abort result",   r,     32'h00000002);
        chk("after abort overflow", W'(o), W'(0));
        chk("after abort latency",  W'(l), W'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
